// File: rtl/lif_layer_scheduler_if.sv
// lif_layer_scheduler_if: start/current/spike/debug-read bundle between aggregation logic and the LIF layer scheduler
interface lif_layer_scheduler_if #(
    parameter int N_NEURON = 8,
    parameter int IDX_W    = 3,
    parameter int V_SIZE   = 5
);
    logic                         start;
    logic [N_NEURON*V_SIZE-1:0]   current_in;
    logic                         busy;
    logic                         done;
    logic [N_NEURON-1:0]          spike_out;
    logic [IDX_W-1:0]             v_rd_idx;
    logic [V_SIZE-2:0]            v_rd_data;

    modport master (
        output start, current_in, v_rd_idx,
        input  busy, done, spike_out, v_rd_data
    );

    modport slave (
        input  start, current_in, v_rd_idx,
        output busy, done, spike_out, v_rd_data
    );
endinterface

// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler: time-multiplexed saturating LIF update over one layer; LIF_SCHED_REFRACT_EN adds one-timestep refractory input suppression
module lif_layer_scheduler #(
    parameter int N_NEURON  = 8,
    parameter int IDX_W     = 3,
    parameter int V_SIZE    = 5,
    parameter int THRESHOLD = 8,
    parameter int V_LEAK    = 1
) (
    input logic                  clk,
    input logic                  rstn,
    lif_layer_scheduler_if.slave bus
);
    localparam int VW = V_SIZE - 1;
    localparam logic [VW-1:0]          INF  = '1;
    localparam logic signed [V_SIZE:0] LEAK = (V_SIZE+1)'(V_LEAK);
    localparam logic [VW:0]            TH   = (VW+1)'(THRESHOLD);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_NEURON*V_SIZE-1:0] cur_q;
    logic [VW-1:0]              v_q [N_NEURON];
    logic [N_NEURON-1:0]        acc_q, acc_d, spike_q;
    logic                       done_q;
    logic                       last;
    logic signed [V_SIZE-1:0]   i_sel, p;
    logic signed [V_SIZE:0]     pl;
    logic [VW-1:0]              v_sel, u, rd_data;
    logic                       fire;
`ifdef LIF_SCHED_REFRACT_EN
    logic [N_NEURON-1:0]        refr_q;
`endif

    assign last = idx_q == IDX_W'(N_NEURON-1);

    // Pick the current and voltage of the neuron being updated this cycle
    always_comb begin
        i_sel = '0;
        v_sel = '0;
        for (int i = 0; i < N_NEURON; i++) begin
            if (idx_q == IDX_W'(i)) begin
                i_sel = cur_q[i*V_SIZE +: V_SIZE];
                v_sel = v_q[i];
`ifdef LIF_SCHED_REFRACT_EN
                if (refr_q[i]) i_sel = '0;
`endif
            end
        end
    end

    // Saturating integrate, leak, threshold; a positive-current wrap means overflow and pins to INF without leak
    always_comb begin
        p    = $signed({1'b0, v_sel}) + i_sel;
        pl   = {p[V_SIZE-1], p} - LEAK;
        u    = (!i_sel[V_SIZE-1] && p[V_SIZE-1]) ? INF :
               (p[V_SIZE-1] || pl[V_SIZE]) ? '0 : pl[VW-1:0];
        fire = {1'b0, u} >= TH;
    end

    // Spike vector of the timestep in flight, with the current neuron's bit merged in
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < N_NEURON; i++)
            if (idx_q == IDX_W'(i)) acc_d[i] = fire;
    end

    // Next state: IDLE waits for start, UPDATE walks idx and returns after the last neuron
    always_comb begin
        state_d = (state_q == IDLE) ? (bus.start ? UPDATE : IDLE) : (last ? IDLE : UPDATE);
        idx_d   = (state_q == UPDATE && !last) ? idx_q + 1'b1 : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Current latch, voltage file, spike collection and done pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_q   <= '0;
            acc_q   <= '0;
            spike_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_NEURON; i++) v_q[i] <= '0;
`ifdef LIF_SCHED_REFRACT_EN
            refr_q  <= '0;
`endif
        end else begin
            done_q <= state_q == UPDATE && last;
            if (state_q == IDLE && bus.start) cur_q <= bus.current_in;
            if (state_q == UPDATE) begin
                acc_q <= acc_d;
                if (last) spike_q <= acc_d;
                for (int i = 0; i < N_NEURON; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        v_q[i] <= fire ? '0 : u;
`ifdef LIF_SCHED_REFRACT_EN
                        refr_q[i] <= fire;
`endif
                    end
                end
            end
        end
    end

    // Debug voltage read; indices beyond the layer read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_NEURON; i++)
            if (bus.v_rd_idx == IDX_W'(i)) rd_data = v_q[i];
    end

    assign bus.v_rd_data = rd_data;
    assign bus.busy      = state_q == UPDATE;
    assign bus.done      = done_q;
    assign bus.spike_out = spike_q;
endmodule

// File: tb/tb_lif_layer_scheduler.sv
// tb_lif_layer_scheduler: directed and random timesteps against an arithmetic LIF reference model
module tb_lif_layer_scheduler;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int VS = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   mv [N];
    bit   mr [N];
    logic [N-1:0]    mspk;
    logic [N*VS-1:0] cv;
    logic [2:0]      seq;

    lif_layer_scheduler_if #(.N_NEURON(N), .IDX_W(IW), .V_SIZE(VS)) bus ();

    lif_layer_scheduler #(
        .N_NEURON(N), .IDX_W(IW), .V_SIZE(VS), .THRESHOLD(8), .V_LEAK(1)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*VS-1:0] setc(input logic [N*VS-1:0] v, input int n, input int val);
        logic [N*VS-1:0] r;
        r = v;
        r[n*VS +: VS] = VS'(val);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
        mspk = '0;
    endfunction

    function automatic void model_step(input logic [N*VS-1:0] cur);
        logic signed [VS-1:0] c;
        int cin, sum, u;
        for (int i = 0; i < N; i++) begin
            c   = cur[i*VS +: VS];
            cin = c;
`ifdef LIF_SCHED_REFRACT_EN
            if (mr[i]) cin = 0;
`endif
            sum = mv[i] + cin;
            if (sum > 15)        u = 15;
            else if (sum - 1 < 0) u = 0;
            else                 u = sum - 1;
            mspk[i] = u >= 8;
            mr[i]   = u >= 8;
            mv[i]   = (u >= 8) ? 0 : u;
        end
    endfunction

    task automatic check_volts(input string tag);
        for (int i = 0; i < N; i++) begin
            bus.v_rd_idx = IW'(i);
            #1;
            chk($sformatf("%s_v%0d", tag, i), 32'(bus.v_rd_data), 32'(mv[i]));
        end
    endtask

    task automatic do_step(input logic [N*VS-1:0] cur, input bit hold);
        int n;
        bus.start      = 1'b1;
        bus.current_in = cur;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        bus.current_in = (N*VS)'({$urandom(), $urandom()});
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_after_start", 32'(bus.done), 32'd0);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_latency", 32'(n), 32'd8);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        model_step(cur);
        chk("spike_out", 32'(bus.spike_out), 32'(mspk));
        check_volts("step");
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.current_in = '0;
        bus.v_rd_idx   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_spike", 32'(bus.spike_out), 32'd0);
        check_volts("rst");

        do_step('0, 1'b0);

        cv = setc('0, 0, 5);
        do_step(cv, 1'b0);
        chk("n0_v_after_1", 32'(mv[0]), 32'd4);
        do_step(cv, 1'b0);
        chk("n0_spike_2", 32'(bus.spike_out[0]), 32'd1);

        cv = setc(setc('0, 3, 5), 5, 4);
        do_step(cv, 1'b0);
        cv = setc(setc('0, 3, 15), 5, -16);
        do_step(cv, 1'b0);
        chk("n3_sat_spike", 32'(bus.spike_out[3]), 32'd1);
        chk("n5_no_spike", 32'(bus.spike_out[5]), 32'd0);

        for (int k = 0; k < 6; k++) do_step((N*VS)'({$urandom(), $urandom()}), 1'b0);

        for (int k = 0; k < 5; k++) do_step((N*VS)'({$urandom(), $urandom()}), k != 4);

        bus.start      = 1'b1;
        bus.current_in = (N*VS)'({$urandom(), $urandom()});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        begin
            bit seen;
            seen = 1'b0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (bus.done) seen = 1'b1;
            end
            chk("midrst_no_done", 32'(seen), 32'd0);
        end
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_spike", 32'(bus.spike_out), 32'd0);
        check_volts("midrst");
        do_step((N*VS)'({$urandom(), $urandom()}), 1'b0);

        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        cv = setc('0, 1, 9);
        for (int k = 0; k < 3; k++) begin
            do_step(cv, 1'b0);
            seq[k] = bus.spike_out[1];
        end
`ifdef LIF_SCHED_REFRACT_EN
        chk("refract_seq", 32'(seq), 32'b101);
`else
        chk("refract_seq", 32'(seq), 32'b111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexes a single leaky-integrate-and-fire update datapath across N_NEURON neurons of one layer.
- Voltages are held in an internal register file. Each timestep is triggered by a start pulse carrying one signed input current per neuron.
- The scheduler walks the neurons one per cycle, applying saturating integrate, leak, threshold and reset. It then emits the layer's spike vector with a done pulse.
- Sits between the input current aggregation logic and the next layer's spike router.

Parameters:
- N_NEURON, 8, number of neurons sequenced (≥2).
- IDX_W, 3, index width; must satisfy 2^IDX_W ≥ N_NEURON.
- V_SIZE, 5, signed current width; stored voltage is V_SIZE-1 bits unsigned.
- THRESHOLD, 8, firing threshold; spike when updated voltage ≥ THRESHOLD.
- V_LEAK, 1, constant subtracted every update.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, synchronous active-low reset.
- start, input, 1, begin a timestep; sampled only in IDLE.
- current_in, input, N_NEURON*V_SIZE, packed signed currents; neuron i at bits [i*V_SIZE +: V_SIZE]; sampled with start.
- busy, output, 1, timestep in progress.
- done, output, 1, one-cycle pulse: spike_out updated.
- spike_out, output, N_NEURON, spike vector of the last completed timestep.
- v_rd_idx, input, IDX_W, debug voltage read index.
- v_rd_data, output, V_SIZE-1, combinational voltage of neuron v_rd_idx; 0 if index ≥ N_NEURON.

Behaviour:
- Clock and reset: rstn is synchronous, active-low; clock is clk.
- Reset values: state IDLE; all voltages 0; busy 0; done 0; spike_out 0; internal index 0; latched currents 0.
- FSM has two states, IDLE and UPDATE.
- IDLE + start: latch current_in, set idx=0, go to UPDATE, busy←1.
- IDLE without start: hold all state.
- UPDATE: each edge updates neuron idx, then idx←idx+1.
- UPDATE, idx==N_NEURON-1: that edge also sets state←IDLE, busy←0, done←1, and loads spike_out with the full vector, including this neuron.
- done is high for exactly one cycle, and otherwise 0.
- Latency: done is registered at the N_NEURON-th edge after the start-sampling edge.
- Throughput: start may be asserted in the cycle where done is high, giving one timestep per N_NEURON+1 cycles.
- start is ignored while busy; current_in changes during UPDATE have no effect.
- Per-neuron update, with INF = 2^(V_SIZE-1)-1:
  - p = {0,v} + I, computed in V_SIZE-bit signed wrap arithmetic.
  - If I ≥ 0 and p is negative (overflow): u = INF, with no leak applied.
  - Else if p < 0 or p−V_LEAK < 0: u = 0.
  - Else: u = p−V_LEAK.
  - spike = (u ≥ THRESHOLD); v ← spike ? 0 : u.
- The spike bit for neuron i is collected in an internal vector. spike_out changes only on the done edge and holds between timesteps.
- Reset mid-UPDATE: abort the timestep; voltages clear; no done is produced.

Optional Feature:
- Macro: LIF_SCHED_REFRACT_EN.
- When defined:
  - Adds a per-neuron refractory flag, reset 0.
  - A neuron that spiked in timestep t has its current forced to 0 for its update in timestep t+1; the leak still applies.
  - The flag is set on the spike and cleared after the suppressed update.
  - A neuron cannot spike in two consecutive timesteps unless its voltage saturates via the overflow path, which is impossible with zero input.
- When undefined: no flags; currents are always applied as latched.

Test Plan:
- Reset, then start with all currents 0 → done exactly 8 edges after the start edge; spike_out=0; all voltages 0; busy high for those 8 cycles.
- Neuron 0 current +5, others 0, two timesteps → v0 reads 4 after the first; after the second, spike_out[0]=1 and v0=0.
- Neuron 3 at v=4 with current +15 → overflow saturates to 15, which fires: spike_out[3]=1, v3=0. Neuron 5 at v=3 with current −16 → v5=0, no spike.
- start held high continuously → back-to-back timesteps, done every 9 cycles; changing current_in mid-UPDATE does not alter results.
- rstn low for one cycle at idx=4 mid-UPDATE → no done; busy=0; all voltages 0; spike_out=0; a next start runs normally.
- With LIF_SCHED_REFRACT_EN: neuron 1 at current +9 for three timesteps → spike_out[1] = 1,0,1. Without the macro → 1,1,1.
